// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide sequencer.
// Opcode and FSM state encodings plus iteration count.
package alu_muldiv_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int ITERS = 8;
  localparam int CNT_W = 3;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 8-bit add/sub ALU shared with the core datapath.
// op=0: a+b, op=1: a+~b+1; carry is the ninth sum bit.
module alu_muldiv_seq_alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  // invert b and inject carry-in for subtract
  always_comb begin
    b_eff = op ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, op};
  end

  assign result = sum[W-1:0];
  assign carry  = sum[W];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 multiply / 8/8 divide sequencer on one add/sub ALU.
// Division path is built only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int          DW        = 8,
  parameter logic [DW-1:0] DIV0_QUOT = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_hi,
  output logic [DW-1:0] rsp_lo,
  output logic          rsp_err
);

  if (DW != 8 || $bits(DIV0_QUOT) != DW) begin : g_dw_chk
    $fatal(1, "alu_muldiv_seq: DW must be 8");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    h_q, h_d;
  logic [DW-1:0]    l_q, l_d;
  logic [DW-1:0]    m_q, m_d;
  logic             err_q, err_d;
  logic             vld_q, vld_d;

  logic [DW-1:0]    alu_a;
  logic             alu_op;
  logic [DW-1:0]    alu_res;
  logic             alu_co;

`ifdef ALU_MULDIV_DIV_EN
  op_e              op_q, op_d;
  logic [DW-1:0]    r_s;
  logic [DW-2:0]    q_s;
`endif

  alu_muldiv_seq_alu #(
    .W (DW)
  ) u_alu (
    .a      (alu_a),
    .b      (m_q),
    .op     (alu_op),
    .result (alu_res),
    .carry  (alu_co)
  );

  // next-state, shift-register and response logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    l_d     = l_q;
    m_d     = m_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    alu_a   = h_q;
    alu_op  = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    op_d    = op_q;
    r_s     = {h_q[DW-2:0], l_q[DW-1]};
    q_s     = l_q[DW-2:0];
    if (op_q == OP_DIV) begin
      alu_a  = r_s;
      alu_op = 1'b1;
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          m_d   = req_b;
          h_d   = '0;
          l_d   = req_a;
          err_d = 1'b0;
          if (req_op == OP_DIV) begin
`ifdef ALU_MULDIV_DIV_EN
            op_d = OP_DIV;
            if (req_b == '0) begin
              h_d     = req_a;
              l_d     = DIV0_QUOT;
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
`else
            l_d     = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
`endif
          end else begin
`ifdef ALU_MULDIV_DIV_EN
            op_d    = OP_MUL;
`endif
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef ALU_MULDIV_DIV_EN
        if (op_q == OP_DIV) begin
          h_d = alu_co ? alu_res : r_s;
          l_d = {q_s, alu_co};
        end else
`endif
        if (l_q[0]) begin
          {h_d, l_d} = {alu_co, alu_res, l_q[DW-1:1]};
        end else begin
          {h_d, l_d} = {1'b0, h_q, l_q[DW-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        vld_d = !(vld_q && rsp_ready);
        if (vld_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      op_q    <= OP_MUL;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      l_q     <= l_d;
      m_q     <= m_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
`ifdef ALU_MULDIV_DIV_EN
      op_q    <= op_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = vld_q;
  assign rsp_hi    = h_q;
  assign rsp_lo    = l_q;
  assign rsp_err   = err_q;

endmodule
